// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Imported by fetch_buffer and fetch_stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int FETCH_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } buf_entry_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry response FIFO between instruction memory and IF/ID.
// Push and pop may occur in the same cycle; clear empties it.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  buf_entry_t din,
  output buf_entry_t head,
  output logic [1:0] occ
);

  buf_entry_t mem [FETCH_BUF_DEPTH];
  logic       rd_ptr;
  logic       wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  // The credit rule upstream must make both of these impossible.
  always_ff @(posedge clk) begin
    if (!reset && !clear) begin
      assert (!(push && !pop && occ == 2'd2));
      assert (!(pop && occ == 2'd0));
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, imem requests, response buffer and IF/ID register.
// Optional FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] OutInstruction,
  output logic        if_id_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  localparam logic [1:0]  ST_IDLE  = IDLE;
  localparam logic [1:0]  ST_RUN   = RUN;
  localparam logic [1:0]  ST_DRAIN = DRAIN;
  localparam logic [2:0]  CREDITS  = 3'(BUF_DEPTH);
  localparam logic [31:0] PC_START = word_align(PC_RESET);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] fetch_pc;
  logic [1:0]  inflight;
  logic [1:0]  inflight_nxt;
  logic [1:0]  drop_cnt;
  logic [1:0]  drop_nxt;
  logic [1:0]  occ;
  logic [31:0] resp_pc;
  buf_entry_t  head;
  buf_entry_t  resp_entry;
  logic        active;
  logic        issue;
  logic        resp;
  logic        good;
  logic        use_buf;
  logic        use_byp;
  logic        push;
  logic        pop;

  assign active    = !reset && (state != ST_IDLE);
  assign imem_req  = active &&
                     (({1'b0, inflight} + {1'b0, occ}) < CREDITS);
  assign imem_addr = fetch_pc;
  assign issue     = imem_req;

  assign resp = active && imem_rvalid;
  assign good = resp && (drop_cnt == 2'd0) && !redirect_valid;

  assign inflight_nxt = inflight + {1'b0, issue} - {1'b0, resp};

  // Responses return in order, so the oldest live request sits
  // inflight words behind the next fetch address.
  assign resp_pc    = fetch_pc - {28'd0, inflight, 2'b00};
  assign resp_entry = '{pc: resp_pc, instr: imem_rdata};

  assign use_buf = !stall && !redirect_valid && (occ != 2'd0);
  assign use_byp = !stall && good && (occ == 2'd0);
  assign pop     = use_buf;
  assign push    = good && !use_byp;

  always_comb begin
    drop_nxt = drop_cnt;
    if (redirect_valid) begin
      drop_nxt = inflight_nxt;
    end else if (resp && drop_cnt != 2'd0) begin
      drop_nxt = drop_cnt - 2'd1;
    end
  end

  always_comb begin
    state_nxt = ST_RUN;
    unique case (1'b1)
      state == ST_IDLE: state_nxt = ST_RUN;
      state != ST_IDLE && drop_nxt != 2'd0: state_nxt = ST_DRAIN;
      default: state_nxt = ST_RUN;
    endcase
  end

  fetch_buffer u_buf (
    .clk   (clk),
    .reset (reset),
    .clear (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (resp_entry),
    .head  (head),
    .occ   (occ)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      fetch_pc       <= PC_START;
      inflight       <= 2'd0;
      drop_cnt       <= 2'd0;
      pc             <= 32'd0;
      OutInstruction <= NOP_INSTR;
      if_id_valid    <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= inflight_nxt;
      drop_cnt <= drop_nxt;
      if (redirect_valid) begin
        fetch_pc       <= word_align(redirect_pc);
        OutInstruction <= NOP_INSTR;
        if_id_valid    <= 1'b0;
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (use_buf) begin
          pc             <= head.pc;
          OutInstruction <= head.instr;
          if_id_valid    <= 1'b1;
        end else if (use_byp) begin
          pc             <= resp_pc;
          OutInstruction <= imem_rdata;
          if_id_valid    <= 1'b1;
        end else if (!stall) begin
          OutInstruction <= NOP_INSTR;
          if_id_valid    <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic loaded;

  assign loaded = use_buf || use_byp;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= 32'd0;
      perf_bubbles <= 32'd0;
    end else begin
      if (loaded && perf_fetched != 32'hFFFF_FFFF) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (!stall && !loaded && perf_bubbles != 32'hFFFF_FFFF) begin
        perf_bubbles <= perf_bubbles + 32'd1;
      end
    end
  end
`endif

endmodule
